// File: rtl/cim_slice_recombiner.sv
// ============================================================================
// Module   : cim_slice_recombiner
// Brief    : Shift-accumulates four 2-bit-slice CIM column partial sums into
//            full-precision dot-product results behind a valid/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cim_slice_recombiner #(
    parameter int N_COL = 8,
    parameter int PS_W  = 12,
    parameter int ACC_W = PS_W + 7,
    parameter int OUT_W = PS_W + 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_slice,
    input  logic signed [PS_W-1:0]  in_psum    [0:N_COL-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_result [0:N_COL-1],
    output logic                    err_seq
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               exp_slice_q, exp_slice_d;
    logic                     err_q, err_d;
    logic signed [ACC_W-1:0]  acc_q    [0:N_COL-1];
    logic signed [ACC_W-1:0]  acc_d    [0:N_COL-1];
    logic signed [OUT_W-1:0]  result_q [0:N_COL-1];
    logic signed [OUT_W-1:0]  result_d [0:N_COL-1];
    logic signed [ACC_W-1:0]  term     [0:N_COL-1];
    logic signed [ACC_W-1:0]  sum      [0:N_COL-1];
    logic                     accept;

    assign out_valid  = (state_q == ST_HOLD);
    assign in_ready   = ~out_valid & ~rst;
    assign accept     = in_valid & in_ready;
    assign err_seq    = err_q;
    assign out_result = result_q;

    always_comb begin
        state_d     = state_q;
        exp_slice_d = exp_slice_q;
        err_d       = 1'b0;
        acc_d       = acc_q;
        result_d    = result_q;
        for (int c = 0; c < N_COL; c++) begin
            term[c] = in_psum[c];
            term[c] = term[c] <<< {in_slice, 1'b0};
            sum[c]  = acc_q[c] + term[c];
        end

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (in_slice == 2'd0) begin
                        // Slice 0 always restarts; an unfinished vector is an error.
                        acc_d       = term;
                        exp_slice_d = 2'd1;
                        err_d       = (exp_slice_q != 2'd0);
                    end else if (in_slice == exp_slice_q) begin
                        if (in_slice == 2'd3) begin
                            // Bit 0 is the splitter's appended zero; drop it.
                            for (int c = 0; c < N_COL; c++) begin
                                result_d[c] = sum[c][OUT_W:1];
                            end
                            state_d     = ST_HOLD;
                            exp_slice_d = 2'd0;
                        end else begin
                            acc_d       = sum;
                            exp_slice_d = exp_slice_q + 2'd1;
                        end
                    end else begin
                        exp_slice_d = 2'd0;
                        err_d       = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            exp_slice_q <= 2'd0;
            err_q       <= 1'b0;
            for (int c = 0; c < N_COL; c++) begin
                acc_q[c]    <= '0;
                result_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            exp_slice_q <= exp_slice_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
        end
    end

endmodule

`default_nettype wire
